// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder.
// Holds the FSM state encoding and the default operand width.
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_add_bit.sv
// One-bit combinational full adder used as the serial adder's datapath slice.
module full_add_bit (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/serial_add.sv
// Bit-serial adder: one bit per clock, LSB first, result latched on completion.
// Start is accepted in IDLE or DONE, ignored while RUN is in progress.
module serial_add
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;

    logic             bit_s;
    logic             bit_co;
    logic [WIDTH-1:0] acc_shifted;

    full_add_bit u_full_add_bit (
        .x  (a_sh_q[0]),
        .y  (b_sh_q[0]),
        .ci (c_q),
        .s  (bit_s),
        .co (bit_co)
    );

    // New result bit enters at the MSB so the LSB-first stream lands in order.
    always_comb begin
        acc_shifted            = acc_q >> 1;
        acc_shifted[WIDTH-1]   = bit_s;
    end

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        cout_d  = cout_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    a_sh_d  = a;
                    b_sh_d  = b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    c_d     = cin;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                acc_d  = acc_shifted;
                c_d    = bit_co;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    sum_d   = acc_shifted;
                    cout_d  = bit_co;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_add.sv
// Directed scoreboard bench for the bit-serial adder at WIDTH=8.
module tb_serial_add;

    localparam int WIDTH = 8;

    typedef struct packed {
        logic             c;
        logic [WIDTH-1:0] s;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a, b;
    logic             cin;
    logic             busy, done, cout;
    logic [WIDTH-1:0] sum;

    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];

    serial_add #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("[TB] check %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic ci);
        logic [WIDTH:0] t;
        t = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
        return exp_t'(t);
    endfunction

    // Drive one accepted start; the bench sits just after the capturing edge on return.
    task automatic launch(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic ci);
        a = x; b = y; cin = ci; start = 1'b1;
        exp_q.push_back(model(x, y, ci));
        step();
        start = 1'b0;
    endtask

    // Follow one operation to its done pulse, optionally pulsing start at edge poke_at.
    task automatic run_op(input string tag, input int poke_at);
        int               busy_cnt;
        int               lat;
        logic             held;
        logic [WIDTH-1:0] sum0;
        logic             c0;
        exp_t             e;
        busy_cnt = 0; lat = -1; held = 1'b1; sum0 = sum; c0 = cout;
        for (int i = 1; i <= WIDTH + 4; i++) begin
            if (busy) busy_cnt++;
            if (sum !== sum0 || cout !== c0) held = 1'b0;
            if (i == poke_at) begin
                start = 1'b1; a = 8'hEE; b = 8'h77; cin = 1'b1;
            end
            step();
            if (i == poke_at) start = 1'b0;
            if (done) begin
                lat = i;
                break;
            end
        end
        check({tag, "_latency"}, 64'(lat), 64'(WIDTH));
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(WIDTH));
        check({tag, "_hold_in_run"}, 64'(held), 64'd1);
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        check({tag, "_sb_depth"}, 64'(exp_q.size()), 64'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_sum"}, 64'(sum), 64'(e.s));
            check({tag, "_cout"}, 64'(cout), 64'(e.c));
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n_done;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        step(); step();
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_sum", 64'(sum), 64'd0);
        check("reset_cout", 64'(cout), 64'd0);
        #2 rst = 1'b0;
        step();

        // Basic add, then single-pulse check on done.
        launch(8'h5A, 8'h3C, 1'b0);
        run_op("basic", 0);
        step();
        check("basic_done_pulse", 64'(done), 64'd0);
        check("basic_sum_hold", 64'(sum), 64'h96);

        // Carry chain corner cases.
        launch(8'hFF, 8'h01, 1'b0);
        run_op("carry1", 0);
        step();
        launch(8'hFF, 8'hFF, 1'b1);
        run_op("carry2", 0);
        step();

        // Start pulsed at edge 3 while busy must be ignored.
        launch(8'h12, 8'h34, 1'b0);
        run_op("busy_start", 3);
        n_done = 0;
        for (int i = 0; i < WIDTH + 3; i++) begin
            step();
            if (done) n_done++;
        end
        check("busy_start_extra_done", 64'(n_done), 64'd0);
        check("busy_start_sum_kept", 64'(sum), 64'h46);

        // Back-to-back: start held high across DONE.
        a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
        exp_q.push_back(model(8'h01, 8'h02, 1'b0));
        step();
        a = 8'h10; b = 8'h20;
        run_op("b2b_first", 0);
        exp_q.push_back(model(8'h10, 8'h20, 1'b0));
        step();
        start = 1'b0;
        check("b2b_restart_busy", 64'(busy), 64'd1);
        check("b2b_restart_done", 64'(done), 64'd0);
        run_op("b2b_second", 0);
        step();

        // Asynchronous reset in the fourth RUN cycle aborts with no done.
        launch(8'h77, 8'h11, 1'b1);
        step(); step(); step();
        #2 rst = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_sum", 64'(sum), 64'd0);
        check("abort_cout", 64'(cout), 64'd0);
        void'(exp_q.pop_front());
        step();
        #2 rst = 1'b0;
        n_done = 0;
        for (int i = 0; i < WIDTH + 2; i++) begin
            step();
            if (done || busy) n_done++;
        end
        check("abort_no_activity", 64'(n_done), 64'd0);
        launch(8'hA5, 8'h5A, 1'b1);
        run_op("after_reset", 0);
        step();

        // A few random operands through the same path.
        for (int k = 0; k < 4; k++) begin
            launch(8'($urandom), 8'($urandom), 1'($urandom));
            run_op($sformatf("rand%0d", k), 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_add.md
SERIAL_ADD -- requirements
Module: serial_add

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits; legal values are 2 to 64.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request for a new addition, sampled on clk.
REQ-005 The block SHALL have port a, input, WIDTH bits: first operand, captured when start is accepted.
REQ-006 The block SHALL have port b, input, WIDTH bits: second operand, captured when start is accepted.
REQ-007 The block SHALL have port cin, input, 1 bit: carry-in, captured when start is accepted.
REQ-008 The block SHALL have port busy, output, 1 bit: high while an addition is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse when sum and cout are updated.
REQ-010 The block SHALL have port sum, output, WIDTH bits: registered result of a+b+cin, modulo 2^WIDTH.
REQ-011 The block SHALL have port cout, output, 1 bit: registered carry-out of the most significant bit.

Function
REQ-012 The block SHALL implement a three-state FSM:
- IDLE -> RUN when start=1, capturing a, b and cin, and clearing the bit counter.
- RUN -> DONE when the bit counter reaches WIDTH-1 and that bit has been processed.
- DONE -> RUN when start=1; DONE -> IDLE otherwise.
REQ-013 In each RUN cycle the block SHALL process exactly one bit, LSB first:
- bit result = a_sh[0] ^ b_sh[0] ^ c_reg;
- c_reg <= majority(a_sh[0], b_sh[0], c_reg);
- operand shift registers shift right by one;
- the bit result shifts into the MSB of the accumulator.
REQ-014 c_reg SHALL be loaded with cin when start is accepted.
REQ-015 On RUN -> DONE the block SHALL copy the completed accumulator to sum and the final carry to cout.
REQ-016 sum and cout SHALL otherwise hold their previous values, including throughout RUN.
REQ-017 busy SHALL be 1 exactly in RUN.
REQ-018 done SHALL be 1 exactly in DONE, for one cycle.
REQ-019 Latency: for start sampled high at edge 0, busy SHALL be high from edge 0 to edge WIDTH, and done SHALL be high from edge WIDTH to edge WIDTH+1, with sum and cout valid from edge WIDTH.
REQ-020 The block SHALL ignore start while in RUN: no recapture of operands and no effect on the current result.
REQ-021 The block SHALL accept start in DONE (back-to-back): new operands are captured, done deasserts next cycle, and busy reasserts.
REQ-022 Operand inputs SHALL be don't-care except at the edge where start is accepted.
REQ-023 The bit counter SHALL be $clog2(WIDTH) bits and SHALL never wrap within an operation.

Reset
REQ-024 While rst=1 the block SHALL force:
- state = IDLE;
- busy = 0, done = 0, sum = 0, cout = 0;
- shift registers, bit counter and c_reg = 0.
REQ-025 Assertion of rst mid-operation SHALL abort the addition with no done pulse.
REQ-026 The first start accepted after rst deasserts SHALL behave as from power-up.

Structure
REQ-027 Package serial_add_pkg SHALL hold the FSM state typedef (IDLE, RUN, DONE) and the default-width constant.
REQ-028 The per-bit arithmetic SHALL be a sub-module full_add_bit, combinational, with inputs x, y, ci and outputs s, co, instantiated once.
REQ-029 All other logic SHALL reside in serial_add.

Verification
REQ-030 Basic add: WIDTH=8, a=0x5A, b=0x3C, cin=0, start for 1 cycle -> done at edge 8 with sum=0x96, cout=0; busy high for exactly 8 cycles.
REQ-031 Carry chain: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-032 Start while busy: start pulsed at edge 3 of an operation with different operands -> the original result is delivered at edge 8; no second done pulse.
REQ-033 Back-to-back: start held high continuously with new operands at each DONE (0x01+0x02, then 0x10+0x20) -> done pulses spaced WIDTH+1 cycles apart, with sums 0x03 then 0x30.
REQ-034 Reset mid-operation: rst pulsed at cycle 4 of RUN -> busy=0, done=0, sum=0, cout=0 immediately (asynchronous); no done pulse; the next start yields a correct result.
